msg_field_parser: RTL and testbench

Datapath stage directly downstream of the FIFO-read stage. It captures one 64-bit message word per handshake and scans it byte-serially, MSB byte first. It extracts the type, length and price fields, checks an XOR checksum, and presents the fields with a one-cycle valid strobe. It then pulses `finished` so the upstream stage returns to idle and fetches the next word.

---
 rtl/msg_field_parser.sv | 120 ++++++++++++
 tb/tb_msg_field_parser.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/msg_field_parser.sv
// Byte-serial message field parser: type/length/price extraction with XOR check.
// Checksum logic built only when MSG_PARSER_CHECKSUM_EN is defined.
module msg_field_parser #(
    parameter int         WordWidth   = 64,
    parameter int         LogWidth    = 3,
    parameter logic [7:0] ACCEPT_TYPE = 8'h00
) (
    input  logic                 block2_clk,
    input  logic                 block2_reset,
    input  logic                 in_valid,
    input  logic [WordWidth-1:0] in_data,
    output logic                 finished,
    output logic                 busy,
    output logic                 out_valid,
    output logic [7:0]           out_type,
    output logic [15:0]          out_length,
    output logic [31:0]          out_price,
    output logic                 out_err
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        CHECK,
        DONE
    } state_t;

    localparam logic [LogWidth-1:0] LastIdx = LogWidth'(7);

    state_t               state;
    logic [WordWidth-1:0] shreg;
    logic [LogWidth-1:0]  cnt;
    logic [7:0]           cur_byte;
    logic                 type_ok;

    assign cur_byte = shreg[WordWidth-1 -: 8];
    assign busy     = (state != IDLE);
    // out_type already holds byte 0 by the time the last byte is consumed
    assign type_ok  = (ACCEPT_TYPE == 8'h00) || (out_type == ACCEPT_TYPE);

`ifdef MSG_PARSER_CHECKSUM_EN
    logic [7:0] acc;
    logic [7:0] rx_chk;

    always_ff @(posedge block2_clk or posedge block2_reset) begin
        if (block2_reset) begin
            acc    <= 8'h00;
            rx_chk <= 8'h00;
        end else if (state == IDLE && in_valid) begin
            acc <= 8'h00;
        end else if (state == SCAN) begin
            if (cnt == LastIdx)
                rx_chk <= cur_byte;
            else
                acc <= acc ^ cur_byte;
        end
    end

    logic chk_bad;
    assign chk_bad = (acc != cur_byte);
`else
    logic chk_bad;
    assign chk_bad = 1'b0;
`endif

    always_ff @(posedge block2_clk or posedge block2_reset) begin
        if (block2_reset) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            finished   <= 1'b0;
            out_valid  <= 1'b0;
            out_err    <= 1'b0;
            out_type   <= 8'h00;
            out_length <= 16'h0000;
            out_price  <= 32'h0000_0000;
        end else begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            finished  <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg <= in_data;
                        cnt   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    shreg <= shreg << 8;
                    cnt   <= cnt + 1'b1;
                    case (int'(cnt))
                        0: out_type          <= cur_byte;
                        1: out_length[15:8]  <= cur_byte;
                        2: out_length[7:0]   <= cur_byte;
                        3: out_price[31:24]  <= cur_byte;
                        4: out_price[23:16]  <= cur_byte;
                        5: out_price[15:8]   <= cur_byte;
                        6: out_price[7:0]    <= cur_byte;
                        default: ;
                    endcase
                    if (cnt == LastIdx) begin
                        state     <= CHECK;
                        out_valid <= type_ok;
                        out_err   <= type_ok && chk_bad;
                    end
                end
                CHECK: begin
                    state    <= DONE;
                    finished <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msg_field_parser.sv
// Randomized bench for msg_field_parser against a cycle-count reference model.
// Two instances: accept-all and type 8'h41 filter.
module tb_msg_field_parser;

    logic        block2_clk = 1'b0;
    logic        block2_reset;
    logic        in_valid;
    logic [63:0] in_data;

    logic        fin_a, busy_a, ov_a, err_a;
    logic [7:0]  typ_a;
    logic [15:0] len_a;
    logic [31:0] prc_a;
    logic        fin_f, busy_f, ov_f, err_f;
    logic [7:0]  typ_f;
    logic [15:0] len_f;
    logic [31:0] prc_f;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 block2_clk = ~block2_clk;

    msg_field_parser #(
        .WordWidth  (64),
        .LogWidth   (3),
        .ACCEPT_TYPE(8'h00)
    ) dut (
        .block2_clk  (block2_clk),
        .block2_reset(block2_reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .finished    (fin_a),
        .busy        (busy_a),
        .out_valid   (ov_a),
        .out_type    (typ_a),
        .out_length  (len_a),
        .out_price   (prc_a),
        .out_err     (err_a)
    );

    msg_field_parser #(
        .WordWidth  (64),
        .LogWidth   (3),
        .ACCEPT_TYPE(8'h41)
    ) dut_f (
        .block2_clk  (block2_clk),
        .block2_reset(block2_reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .finished    (fin_f),
        .busy        (busy_f),
        .out_valid   (ov_f),
        .out_type    (typ_f),
        .out_length  (len_f),
        .out_price   (prc_f),
        .out_err     (err_f)
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // reference model: capture edge number and word; timing by arithmetic
    int          edge_n = 0;
    int          cap = 0;
    bit          active = 0;
    logic [63:0] word = '0;
    logic [63:0] held = '0;
    int          ov_count = 0;
    int          last_ov = -100;

    function automatic bit sum_bad(input logic [63:0] w);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < 7; i++)
            x = x ^ w[63 - 8*i -: 8];
`ifdef MSG_PARSER_CHECKSUM_EN
        return x != w[7:0];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [63:0] mk_word(input logic [7:0] t,
                                            input bit good);
        logic [63:0] w;
        logic [7:0]  x;
        w = {t, 32'($urandom), 16'($urandom), 8'h00};
        x = 8'h00;
        for (int i = 0; i < 7; i++)
            x = x ^ w[63 - 8*i -: 8];
        w[7:0] = good ? x : (x ^ 8'(1 + $urandom_range(0, 254)));
        return w;
    endfunction

    task automatic check_side(input string nm,
                              input bit acc_ok,
                              input logic fin, input logic bsy,
                              input logic ov, input logic er,
                              input logic [7:0] t,
                              input logic [15:0] l,
                              input logic [31:0] p);
        int          d;
        logic [63:0] f;
        d = edge_n - cap;
        check({nm, "_busy"}, 64'(bsy), 64'(active));
        check({nm, "_fin"}, 64'(fin), 64'(active && d == 9));
        check({nm, "_valid"}, 64'(ov), 64'(active && d == 8 && acc_ok));
        check({nm, "_err"}, 64'(er),
              64'(active && d == 8 && acc_ok && sum_bad(word)));
        if (!active || d >= 8) begin
            f = active ? word : held;
            check({nm, "_type"}, 64'(t), 64'(f[63:56]));
            check({nm, "_len"}, 64'(l), 64'(f[55:40]));
            check({nm, "_price"}, 64'(p), 64'(f[39:8]));
        end
    endtask

    task automatic check_all;
        check_side("a", 1'b1, fin_a, busy_a, ov_a, err_a,
                   typ_a, len_a, prc_a);
        check_side("f", word[63:56] == 8'h41, fin_f, busy_f,
                   ov_f, err_f, typ_f, len_f, prc_f);
        if (active && edge_n - cap == 8) begin
            if (ov_count > 0 && last_ov == edge_n - 11)
                check("b2b_gap", 64'(edge_n - last_ov), 64'd11);
            ov_count++;
            last_ov = edge_n;
        end
    endtask

    task automatic check_zero;
        check("rst_a", {busy_a, fin_a, ov_a, err_a, typ_a, len_a,
                        prc_a}, 64'd0);
        check("rst_f", {busy_f, fin_f, ov_f, err_f, typ_f, len_f,
                        prc_f}, 64'd0);
    endtask

    // called at a negedge: drive, clock, update model, check
    task automatic cycle(input logic v, input logic [63:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge block2_clk);
        edge_n++;
        if (active && edge_n == cap + 10) begin
            active = 0;
            held   = word;
        end else if (!active && v) begin
            active = 1;
            cap    = edge_n;
            word   = d;
        end
        @(negedge block2_clk);
        check_all();
    endtask

    task automatic do_reset;
        block2_reset = 1'b1;
        in_valid     = 1'b0;
        #1;
        check_zero();
        active = 0;
        held   = '0;
        @(posedge block2_clk);
        edge_n++;
        @(negedge block2_clk);
        check_zero();
        block2_reset = 1'b0;
    endtask

    logic [63:0] w;

    initial begin
        block2_reset = 1'b1;
        in_valid     = 1'b0;
        in_data      = '0;
        repeat (2) @(negedge block2_clk);
        check_zero();
        block2_reset = 1'b0;

        // reference message, accepted by both instances
        cycle(1'b1, 64'h41001000_0003E8BA);
        repeat (11) cycle(1'b0, '0);
        check("ref_type", 64'(typ_a), 64'h41);
        check("ref_len", 64'(len_a), 64'h0010);
        check("ref_price", 64'(prc_a), 64'h0000_03E8);

        // bad checksum
        cycle(1'b1, 64'h41001000_0003E800);
        repeat (11) cycle(1'b0, '0);

        // filtered type on dut_f
        cycle(1'b1, mk_word(8'h44, 1'b1));
        repeat (11) cycle(1'b0, '0);

        // reset mid-scan, then fresh word
        cycle(1'b1, mk_word(8'h41, 1'b1));
        repeat (3) cycle(1'b0, '0);
        do_reset();
        cycle(1'b1, 64'h41001000_0003E8BA);
        repeat (11) cycle(1'b0, '0);

        // back-to-back with in_valid held high and changing data
        for (int i = 0; i < 30; i++)
            cycle(1'b1, mk_word(8'(i[0] ? 8'h41 : 8'h44),
                                i[1]));
        repeat (11) cycle(1'b0, '0);

        // randomized traffic with stray in_valid and rare resets
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 2))
                0: w = mk_word(8'h41, $urandom_range(0, 1) == 1);
                1: w = mk_word(8'h44, $urandom_range(0, 1) == 1);
                default: w = mk_word(8'($urandom),
                                     $urandom_range(0, 1) == 1);
            endcase
            if ($urandom_range(0, 199) == 0)
                do_reset();
            else
                cycle($urandom_range(0, 2) == 0, w);
        end
        repeat (12) cycle(1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
